microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Parametrised microcode engine for the BasicCPU. Replaces fixed unrolled opcode tables.
//  Holds NUM_PROGS loadable microprograms in one word-addressed store.
//  Issues one program's opcodes to the CPU over a valid/ready handshake.
//  Patches the argument into flagged words and honours CPU skip requests,
//  so loops no longer need to be unrolled per argument width.
// PARAMETERS
//  OPCODE_W   12   opcode width issued to the CPU
//  DEPTH      128  microcode store depth, words (ADDR_W = $clog2(DEPTH))
//  NUM_PROGS  4    program table entries (PSEL_W = $clog2(NUM_PROGS), min 1)
//  ARG_W      4    argument width patched into opcode[ARG_W-1:0]; ARG_W <= OPCODE_W
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  ld_we        in   1          write microcode word; ignored unless busy=0
//  ld_addr      in   ADDR_W     store address
//  ld_data      in   OPCODE_W+1 {patch_flag, opcode}
//  tbl_we       in   1          write program table entry; ignored unless busy=0
//  tbl_idx      in   PSEL_W     entry index
//  tbl_first    in   ADDR_W     first word of program
//  tbl_last     in   ADDR_W     last word of program, inclusive
//  start        in   1          request program run; sampled only in IDLE
//  prog_sel     in   PSEL_W     program to run
//  arg          in   ARG_W      argument for patched words
//  abort        in   1          terminate current run
//  op_valid     out  1          opcode presented
//  op_ready     in   1          CPU accepts opcode
//  opcode       out  OPCODE_W   opcode to CPU
//  skip         in   1          with handshake: skip next word (CPU skipif true)
//  busy         out  1          high in any state but IDLE
//  done         out  1          1-cycle pulse, program ran to completion
//  err          out  1          1-cycle pulse, start rejected
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=IDLE; pc=0; op_valid, opcode, busy, done, err = 0.
//   - Table entries reset to first=last=0 with valid=0.
//   - Store contents undefined after reset. Every entry is invalid until written.
//  Store: synchronous read, 1-cycle latency. A tbl_we write marks that entry valid.
//  States: IDLE -> FETCH -> ISSUE -> (FETCH | DONE) -> IDLE.
//  IDLE:
//   - start=1 with a valid entry where first<=last: pc<=first, go to FETCH.
//   - start=1 with an invalid entry, first>last, or prog_sel>=NUM_PROGS:
//     err=1 for 1 cycle, stay in IDLE.
//  FETCH: store read at pc. Next edge: opcode<=word[OPCODE_W-1:0]; ISSUE with op_valid=1.
//  Patch: if word[OPCODE_W]=1, opcode[ARG_W-1:0] is replaced by arg.
//   - arg is latched at start, so later changes to the arg input do not affect the run.
//   - Upper opcode bits are never modified.
//  ISSUE:
//   - opcode and op_valid stay stable until op_ready=1. No retraction except on abort.
//   - Handshake: step = skip ? 2 : 1.
//   - If pc+step > last (compare at ADDR_W+1 bits, no wrap): go to DONE.
//   - Otherwise pc<=pc+step, go to FETCH.
//   - skip is ignored when there is no handshake.
//  Timing:
//   - First op_valid is high 2 cycles after the start edge.
//   - Next op_valid is high 2 cycles after each handshake, so peak rate is 1 op per 2 cycles.
//   - op_valid drops in the cycle after each handshake.
//  DONE: done=1 for 1 cycle, then IDLE. A start in the same cycle as done is ignored.
//  abort=1 in any non-IDLE state:
//   - Next edge: IDLE, op_valid=0, no done.
//   - abort beats a simultaneous handshake: that opcode counts as consumed.
//  ld_we / tbl_we while busy=1 are dropped and never alter the running program.
//  A reset mid-run returns to IDLE immediately, with op_valid=0 asynchronously.
// TESTING
//  1 Load words 0..3 = {0,012},{1,0A0},{0,5A0},{0,1F0}; table0=(0,3); start prog0, arg=5.
//    -> opcodes 012,0A5,5A0,1F0 in order; done 1 cycle after the 4th handshake; busy low next.
//  2 Same program with op_ready held low 5 cycles on op 2.
//    -> opcode stays 0A5 with op_valid=1 throughout; then the sequence continues unchanged.
//  3 Same program with skip=1 on the handshake of op 1.
//    -> ops 012,5A0,1F0. Then table0=(0,1) with skip on op 1 -> op 012 only, then done.
//  4 start prog_sel=2 with entry 2 never written, and start with first=5,last=3.
//    -> err pulse each time, busy stays 0, no op_valid.
//  5 abort during op 3 (op_ready=0). -> op_valid=0 next cycle, IDLE, no done.
//    Restart prog0 -> full sequence from word 0.
//  6 reset=0 while op_valid=1 -> all outputs 0 at once. After release: no op_valid without start.
//    ld_we during busy -> store unchanged (verify on rerun).

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the BasicCPU.
// Holds several loadable microprograms in one word-addressed store and issues
// one of them to the CPU over a valid/ready handshake. Flagged words get the
// run argument patched into their low bits. The CPU may skip the next word.
module microcode_sequencer #(
  parameter  int OPCODE_W  = 12,
  parameter  int DEPTH     = 128,
  parameter  int NUM_PROGS = 4,
  parameter  int ARG_W     = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int PSEL_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [OPCODE_W:0]   ld_data,
  input  logic                tbl_we,
  input  logic [PSEL_W-1:0]   tbl_idx,
  input  logic [ADDR_W-1:0]   tbl_first,
  input  logic [ADDR_W-1:0]   tbl_last,
  input  logic                start,
  input  logic [PSEL_W-1:0]   prog_sel,
  input  logic [ARG_W-1:0]    arg,
  input  logic                abort,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [OPCODE_W-1:0] opcode,
  input  logic                skip,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bits of the opcode that the argument replaces in flagged words. The shift
  // form still yields all ones when ARG_W equals OPCODE_W.
  localparam logic [OPCODE_W-1:0] ARG_MASK = (OPCODE_W'(1) << ARG_W) - OPCODE_W'(1);

  logic [1:0]          state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   last_q;
  logic [ARG_W-1:0]    arg_q;

  logic [OPCODE_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   tbl_first_q [NUM_PROGS];
  logic [ADDR_W-1:0]   tbl_last_q  [NUM_PROGS];
  logic [NUM_PROGS-1:0] tbl_valid_q;

  logic                sel_in_range;
  logic                start_ok;
  logic [ADDR_W:0]     pc_next;
  logic [OPCODE_W:0]   word;
  logic [OPCODE_W-1:0] patched;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Store writes; only accepted while idle so a running program never changes.
  // NOTE: the store has no reset -- clearing a RAM array prevents block-RAM
  // inference, and its contents are defined as undefined until written.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Program table: entries come up invalid and become valid when written while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        tbl_first_q[i] <= '0;
        tbl_last_q[i]  <= '0;
      end
      tbl_valid_q <= '0;
    end else if (tbl_we && !busy) begin
      tbl_first_q[tbl_idx] <= tbl_first;
      tbl_last_q[tbl_idx]  <= tbl_last;
      tbl_valid_q[tbl_idx] <= 1'b1;
    end
  end

  // Start qualification, next word address and argument patching.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_in_range = ({1'b0, prog_sel} < (PSEL_W + 1)'(NUM_PROGS));
    start_ok     = 1'b0;
    if (sel_in_range) begin
      start_ok = tbl_valid_q[prog_sel] && (tbl_first_q[prog_sel] <= tbl_last_q[prog_sel]);
    end
    // One extra bit so a step past the top of the store cannot wrap below last.
    pc_next = {1'b0, pc} + (skip ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));
    word    = mem[pc];
    patched = word[OPCODE_W-1:0];
    if (word[OPCODE_W]) begin
      patched = (word[OPCODE_W-1:0] & ~ARG_MASK) | (OPCODE_W'(arg_q) & ARG_MASK);
    end
  end

  // Sequencing FSM; the opcode register doubles as the store's read register.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      last_q   <= '0;
      arg_q    <= '0;
      op_valid <= 1'b0;
      opcode   <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort && busy) begin
        // Abort wins over a same-cycle handshake; that opcode counts as taken.
        state    <= S_IDLE;
        op_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (start_ok) begin
                pc     <= tbl_first_q[prog_sel];
                last_q <= tbl_last_q[prog_sel];
                arg_q  <= arg;
                state  <= S_FETCH;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            opcode   <= patched;
            op_valid <= 1'b1;
            state    <= S_ISSUE;
          end
          S_ISSUE: begin
            if (op_ready) begin
              op_valid <= 1'b0;
              if (pc_next > {1'b0, last_q}) begin
                state <= S_DONE;
              end else begin
                pc    <= pc_next[ADDR_W-1:0];
                state <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: full runs, stalls, skips, rejected
// starts, abort, mid-run reset and writes attempted while busy.
module tb_microcode_sequencer;

  localparam int OPCODE_W = 12;
  localparam int ADDR_W   = 7;
  localparam int PSEL_W   = 2;
  localparam int ARG_W    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                ld_we;
  logic [ADDR_W-1:0]   ld_addr;
  logic [OPCODE_W:0]   ld_data;
  logic                tbl_we;
  logic [PSEL_W-1:0]   tbl_idx;
  logic [ADDR_W-1:0]   tbl_first;
  logic [ADDR_W-1:0]   tbl_last;
  logic                start;
  logic [PSEL_W-1:0]   prog_sel;
  logic [ARG_W-1:0]    arg;
  logic                abort;
  logic                op_valid;
  logic                op_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                skip;
  logic                busy;
  logic                done;
  logic                err;

  int n_tests = 0;
  int n_fail  = 0;

  microcode_sequencer dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_first(tbl_first), .tbl_last(tbl_last),
    .start(start), .prog_sel(prog_sel), .arg(arg), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .skip(skip),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic flag, input logic [11:0] op);
    ld_we = 1'b1; ld_addr = ADDR_W'(addr); ld_data = {flag, op};
    tick();
    ld_we = 1'b0;
  endtask

  task automatic set_tbl(input int idx, input int first, input int last);
    tbl_we = 1'b1; tbl_idx = PSEL_W'(idx); tbl_first = ADDR_W'(first); tbl_last = ADDR_W'(last);
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic expect_err(input string tag, input int sel);
    start = 1'b1; prog_sel = PSEL_W'(sel);
    tick();
    start = 1'b0;
    check({tag, " err"},  32'(err), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    tick();
    check({tag, " err drop"}, 32'(err), 32'd0);
    check({tag, " no op"},    32'(op_valid), 32'd0);
  endtask

  // Runs one program; skip_at / stall_at / abort_at select the op index (or -1).
  // poke attempts store and table writes in the cycle after start.
  task automatic run_prog(input string tag, input int sel, input logic [3:0] a,
                          input logic [11:0] exp_ops[4], input int n_ops,
                          input int skip_at, input int stall_at, input int stall_n,
                          input int abort_at, input bit poke);
    start = 1'b1; prog_sel = PSEL_W'(sel); arg = a;
    tick();
    start = 1'b0;
    arg   = ~a;  // argument must have been latched at start
    check({tag, " fetch valid"}, 32'(op_valid), 32'd0);
    check({tag, " busy"},        32'(busy), 32'd1);
    if (poke) begin
      ld_we  = 1'b1; ld_addr = 7'd1; ld_data = {1'b0, 12'hFFF};
      tbl_we = 1'b1; tbl_idx = 2'd0; tbl_first = 7'd2; tbl_last = 7'd2;
    end
    tick();
    ld_we = 1'b0; tbl_we = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      check($sformatf("%s op%0d valid", tag, i), 32'(op_valid), 32'd1);
      check($sformatf("%s op%0d code", tag, i),  32'(opcode), 32'(exp_ops[i]));
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, " abort valid"}, 32'(op_valid), 32'd0);
        check({tag, " abort busy"},  32'(busy), 32'd0);
        check({tag, " abort done"},  32'(done), 32'd0);
        tick();
        check({tag, " abort done2"}, 32'(done), 32'd0);
        return;
      end
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("%s stall%0d valid", tag, s), 32'(op_valid), 32'd1);
          check($sformatf("%s stall%0d code", tag, s),  32'(opcode), 32'(exp_ops[i]));
        end
      end
      op_ready = 1'b1;
      skip     = (i == skip_at);
      tick();
      op_ready = 1'b0;
      skip     = 1'b0;
      check($sformatf("%s op%0d drop", tag, i), 32'(op_valid), 32'd0);
      if (i == n_ops - 1) begin
        check({tag, " done"}, 32'(done), 32'd1);
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle"},       32'(busy), 32'd0);
      end else begin
        check($sformatf("%s op%0d nodone", tag, i), 32'(done), 32'd0);
        tick();
      end
    end
  endtask

  logic [11:0] seq_full[4];
  logic [11:0] seq_skip[4];
  logic [11:0] seq_one[4];

  initial begin
    seq_full = '{12'h012, 12'h0A5, 12'h5A0, 12'h1F0};
    seq_skip = '{12'h012, 12'h5A0, 12'h1F0, 12'h000};
    seq_one  = '{12'h012, 12'h000, 12'h000, 12'h000};

    reset = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    tbl_we = 1'b0; tbl_idx = '0; tbl_first = '0; tbl_last = '0;
    start = 1'b0; prog_sel = '0; arg = '0; abort = 1'b0; op_ready = 1'b0; skip = 1'b0;
    tick();
    check("rst op_valid", 32'(op_valid), 32'd0);
    check("rst opcode",   32'(opcode), 32'd0);
    check("rst busy",     32'(busy), 32'd0);
    check("rst done",     32'(done), 32'd0);
    check("rst err",      32'(err), 32'd0);
    reset = 1'b1;
    tick();

    // 1: basic program with patched word 1
    load_word(0, 1'b0, 12'h012);
    load_word(1, 1'b1, 12'h0A0);
    load_word(2, 1'b0, 12'h5A0);
    load_word(3, 1'b0, 12'h1F0);
    set_tbl(0, 0, 3);
    run_prog("t1", 0, 4'h5, seq_full, 4, -1, -1, 0, -1, 1'b0);

    // 2: five-cycle stall on op 2
    run_prog("t2", 0, 4'h5, seq_full, 4, -1, 1, 5, -1, 1'b0);

    // 3: skip on the first handshake, then a two-word program skipping past its end
    run_prog("t3a", 0, 4'h5, seq_skip, 3, 0, -1, 0, -1, 1'b0);
    set_tbl(0, 0, 1);
    run_prog("t3b", 0, 4'h5, seq_one, 1, 0, -1, 0, -1, 1'b0);
    set_tbl(0, 0, 3);

    // 4: rejected starts
    expect_err("t4 unwritten", 2);
    set_tbl(3, 5, 3);
    expect_err("t4 first>last", 3);

    // 5: abort while op 3 waits, then a full restart
    run_prog("t5 abort", 0, 4'h5, seq_full, 4, -1, -1, 0, 2, 1'b0);
    run_prog("t5 rerun", 0, 4'h5, seq_full, 4, -1, -1, 0, -1, 1'b0);

    // 6: reset while an opcode is presented
    start = 1'b1; prog_sel = 2'd0; arg = 4'h5;
    tick();
    start = 1'b0;
    tick();
    check("t6 pre valid", 32'(op_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6 async valid",  32'(op_valid), 32'd0);
    check("t6 async opcode", 32'(opcode), 32'd0);
    check("t6 async busy",   32'(busy), 32'd0);
    check("t6 async done",   32'(done), 32'd0);
    check("t6 async err",    32'(err), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6 quiet%0d", i), 32'(op_valid), 32'd0);
    end
    // Table was cleared by reset, so entry 0 is invalid again
    expect_err("t6 tbl cleared", 0);
    set_tbl(0, 0, 3);
    // Writes while busy must be dropped: same sequence now and on the rerun
    run_prog("t6 poke", 0, 4'h5, seq_full, 4, -1, -1, 0, -1, 1'b1);
    run_prog("t6 rerun", 0, 4'h5, seq_full, 4, -1, -1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
